core_lsu_dm_arbiter: RTL and testbench

Shares one dram_manager op channel and one write channel between the two LSU M2 pipes (pipe0 = older in program order, pipe1 = younger). It locks the op channel for refill, uncached-read and cacop requests until dram_manager completion, and arbitrates same-cycle writes in program order. It also blocks writes that hazard against an in-flight op, and bounds pipe1 starvation with a counter. It sits between the two M2 LSU request ports and the dram_manager request/response ports.

---
 rtl/core_lsu_dm_arbiter_if.sv | 86 ++++++++
 rtl/core_lsu_dm_arbiter.sv | 174 +++++++++++++++++
 tb/tb_core_lsu_dm_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_lsu_dm_arbiter_if.sv
// ---------------------------------------------------------------------------
// core_lsu_dm_arbiter_if
// Bundles both LSU M2 request ports and the dram_manager request/response
// ports that core_lsu_dm_arbiter sits between.
//   master : arbiter view (consumes pN_* requests, drives dm_* requests)
//   slave  : environment view (LSU pipes + dram_manager)
// Port summary (N = 0 older pipe, N = 1 younger pipe):
//   pN_op_valid/type/addr -> pN_op_ready   op request, completion pulse
//   pN_we_valid/addr/data/strobe/sel/uncached -> pN_we_ready   write request
//   dm_op_valid/type/addr -> dm_op_ready   op channel to dram_manager
//   dm_we_valid/data/strobe/sel/uncached -> dm_we_ready   write channel
//
// Handshake semantics: an op request (pN_op_valid) is held by the requester
// until pN_op_ready pulses for one cycle; dropping valid early aborts it.
// dm_op_valid stays high for the whole grant and dm_op_ready is a one-cycle
// completion. A write transfers in any cycle where valid and ready are both
// high; ready may depend combinationally on valid.
// ---------------------------------------------------------------------------
`ifndef _DWAY_CNT
`define _DWAY_CNT 2
`endif

interface core_lsu_dm_arbiter_if #(
   parameter int WAY_CNT = `_DWAY_CNT
);
   logic                p0_op_valid;
   logic [3:0]          p0_op_type;
   logic [31:0]         p0_op_addr;
   logic                p0_op_ready;
   logic                p1_op_valid;
   logic [3:0]          p1_op_type;
   logic [31:0]         p1_op_addr;
   logic                p1_op_ready;

   logic                p0_we_valid;
   logic [31:0]         p0_we_addr;
   logic [31:0]         p0_we_data;
   logic [3:0]          p0_we_strobe;
   logic [WAY_CNT-1:0]  p0_we_sel;
   logic                p0_we_uncached;
   logic                p0_we_ready;
   logic                p1_we_valid;
   logic [31:0]         p1_we_addr;
   logic [31:0]         p1_we_data;
   logic [3:0]          p1_we_strobe;
   logic [WAY_CNT-1:0]  p1_we_sel;
   logic                p1_we_uncached;
   logic                p1_we_ready;

   logic                dm_op_valid;
   logic [3:0]          dm_op_type;
   logic [31:0]         dm_op_addr;
   logic                dm_op_ready;
   logic                dm_we_valid;
   logic [31:0]         dm_we_data;
   logic [3:0]          dm_we_strobe;
   logic [WAY_CNT-1:0]  dm_we_sel;
   logic                dm_we_uncached;
   logic                dm_we_ready;

   modport master (
      input  p0_op_valid, p0_op_type, p0_op_addr,
      input  p1_op_valid, p1_op_type, p1_op_addr,
      output p0_op_ready, p1_op_ready,
      input  p0_we_valid, p0_we_addr, p0_we_data, p0_we_strobe, p0_we_sel, p0_we_uncached,
      input  p1_we_valid, p1_we_addr, p1_we_data, p1_we_strobe, p1_we_sel, p1_we_uncached,
      output p0_we_ready, p1_we_ready,
      output dm_op_valid, dm_op_type, dm_op_addr,
      input  dm_op_ready,
      output dm_we_valid, dm_we_data, dm_we_strobe, dm_we_sel, dm_we_uncached,
      input  dm_we_ready
   );

   modport slave (
      output p0_op_valid, p0_op_type, p0_op_addr,
      output p1_op_valid, p1_op_type, p1_op_addr,
      input  p0_op_ready, p1_op_ready,
      output p0_we_valid, p0_we_addr, p0_we_data, p0_we_strobe, p0_we_sel, p0_we_uncached,
      output p1_we_valid, p1_we_addr, p1_we_data, p1_we_strobe, p1_we_sel, p1_we_uncached,
      input  p0_we_ready, p1_we_ready,
      input  dm_op_valid, dm_op_type, dm_op_addr,
      output dm_op_ready,
      input  dm_we_valid, dm_we_data, dm_we_strobe, dm_we_sel, dm_we_uncached,
      output dm_we_ready
   );
endinterface

// File: rtl/core_lsu_dm_arbiter.sv
// ---------------------------------------------------------------------------
// core_lsu_dm_arbiter
// Shares one dram_manager op channel and one write channel between the two
// LSU M2 pipes (pipe0 older, pipe1 younger in program order).
//   clk, rst_n  : clock, synchronous active-low reset
//   bus         : core_lsu_dm_arbiter_if.master (all request/response ports)
//   dbg_state   : one-hot op FSM state (IDLE / GNT0 / GNT1)
//   dbg_starve  : pipe1 op-channel starvation counter
// The op channel is locked from grant until dm_op_ready. Writes are
// arbitrated combinationally in program order and are held off while they
// could collide with the in-flight op (uncached, or same cache index).
// ---------------------------------------------------------------------------
`ifndef _DWAY_CNT
`define _DWAY_CNT 2
`endif

module core_lsu_dm_arbiter #(
   parameter int WAY_CNT      = `_DWAY_CNT,
   parameter int IDX_LO       = 4,
   parameter int IDX_HI       = 11,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   core_lsu_dm_arbiter_if.master bus,
   output logic [2:0]            dbg_state,
   output logic [7:0]            dbg_starve
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'b001,
      ST_GNT0 = 3'b010,
      ST_GNT1 = 3'b100
   } state_e;

   localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

   state_e      state_q, state_d;
   logic [3:0]  op_type_q, op_type_d;
   logic [31:0] op_addr_q, op_addr_d;
   logic [7:0]  starve_q, starve_d;
   logic        enter_gnt1;

   // ------------------------------------------------------------------
   // Op FSM next state, op latch and starvation counter
   // ------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      op_type_d  = op_type_q;
      op_addr_d  = op_addr_q;
      starve_d   = starve_q;
      enter_gnt1 = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // A saturated counter lets pipe1 jump ahead of pipe0.
            if ((starve_q == STARVE_MAX) && bus.p1_op_valid) begin
               state_d    = ST_GNT1;
               op_type_d  = bus.p1_op_type;
               op_addr_d  = bus.p1_op_addr;
               enter_gnt1 = 1'b1;
            end else if (bus.p0_op_valid) begin
               state_d   = ST_GNT0;
               op_type_d = bus.p0_op_type;
               op_addr_d = bus.p0_op_addr;
            end else if (bus.p1_op_valid) begin
               state_d    = ST_GNT1;
               op_type_d  = bus.p1_op_type;
               op_addr_d  = bus.p1_op_addr;
               enter_gnt1 = 1'b1;
            end
         end
         // The grant is held even if the requester aborts, so dram_manager
         // always finishes the op it started; the IDLE bubble afterwards
         // keeps a stale valid from being regranted.
         ST_GNT0, ST_GNT1: begin
            if (bus.dm_op_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (!bus.p1_op_valid || enter_gnt1) begin
         starve_d = 8'd0;
      end else if ((state_q != ST_GNT1) && (starve_q != STARVE_MAX)) begin
         starve_d = starve_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         op_type_q <= 4'd0;
         op_addr_q <= 32'd0;
         starve_q  <= 8'd0;
      end else begin
         state_q   <= state_d;
         op_type_q <= op_type_d;
         op_addr_q <= op_addr_d;
         starve_q  <= starve_d;
      end
   end

   // ------------------------------------------------------------------
   // Op channel outputs (registered state, gated to 0 while in reset)
   // ------------------------------------------------------------------
   logic op_busy;
   logic op_out_en;

   assign op_busy   = (state_q == ST_GNT0) || (state_q == ST_GNT1);
   assign op_out_en = rst_n & op_busy;

   assign bus.dm_op_valid = op_out_en;
   assign bus.dm_op_type  = op_out_en ? op_type_q : 4'd0;
   assign bus.dm_op_addr  = op_out_en ? op_addr_q : 32'd0;

   assign bus.p0_op_ready = rst_n & (state_q == ST_GNT0) & bus.dm_op_ready & bus.p0_op_valid;
   assign bus.p1_op_ready = rst_n & (state_q == ST_GNT1) & bus.dm_op_ready & bus.p1_op_valid;

   // ------------------------------------------------------------------
   // Write path: hazard check and program-order selection
   // ------------------------------------------------------------------
   logic hazard_0, hazard_1;
   logic sel0, sel1;

   assign hazard_0 = op_busy & (bus.p0_we_uncached |
                     (bus.p0_we_addr[IDX_HI:IDX_LO] == op_addr_q[IDX_HI:IDX_LO]));
   assign hazard_1 = op_busy & (bus.p1_we_uncached |
                     (bus.p1_we_addr[IDX_HI:IDX_LO] == op_addr_q[IDX_HI:IDX_LO]));

   // Any pending pipe0 write, even a hazarded one, blocks pipe1 so stores
   // never reach the cache out of program order.
   assign sel0 = rst_n & bus.p0_we_valid & ~hazard_0;
   assign sel1 = rst_n & bus.p1_we_valid & ~bus.p0_we_valid & ~hazard_1;

   logic [31:0]        we_data_mux;
   logic [3:0]         we_strobe_mux;
   logic [WAY_CNT-1:0] we_sel_mux;
   logic               we_unc_mux;

   always_comb begin
      we_data_mux   = 32'd0;
      we_strobe_mux = 4'd0;
      we_sel_mux    = '0;
      we_unc_mux    = 1'b0;
      if (sel0) begin
         we_data_mux   = bus.p0_we_data;
         we_strobe_mux = bus.p0_we_strobe;
         we_sel_mux    = bus.p0_we_sel;
         we_unc_mux    = bus.p0_we_uncached;
      end else if (sel1) begin
         we_data_mux   = bus.p1_we_data;
         we_strobe_mux = bus.p1_we_strobe;
         we_sel_mux    = bus.p1_we_sel;
         we_unc_mux    = bus.p1_we_uncached;
      end
   end

   assign bus.dm_we_valid    = sel0 | sel1;
   assign bus.dm_we_data     = we_data_mux;
   assign bus.dm_we_strobe   = we_strobe_mux;
   assign bus.dm_we_sel      = we_sel_mux;
   assign bus.dm_we_uncached = we_unc_mux;

   assign bus.p0_we_ready = sel0 & bus.dm_we_ready;
   assign bus.p1_we_ready = sel1 & bus.dm_we_ready;

   // Only the index bits of the write address matter here.
   logic unused_we_addr;
   assign unused_we_addr = ^{bus.p0_we_addr, bus.p1_we_addr};

   assign dbg_state  = state_q;
   assign dbg_starve = starve_q;

endmodule

// File: tb/tb_core_lsu_dm_arbiter.sv
// ---------------------------------------------------------------------------
// tb_core_lsu_dm_arbiter
// Vector table for the write path, hand-written sequences for the op
// channel corner cases, then randomized traffic against a reference model.
// ---------------------------------------------------------------------------
module tb_core_lsu_dm_arbiter;
   localparam int WAYS  = 2;
   localparam int LIMIT = 2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   core_lsu_dm_arbiter_if #(.WAY_CNT(WAYS)) bus();
   logic [2:0] dbg_state;
   logic [7:0] dbg_starve;

   core_lsu_dm_arbiter #(
      .WAY_CNT(WAYS), .IDX_LO(4), .IDX_HI(11), .STARVE_LIMIT(LIMIT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.master),
      .dbg_state(dbg_state), .dbg_starve(dbg_starve)
   );

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_q[$];

   initial begin
      #2000000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers / driver tasks ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic drive_op(input int pipe, input logic v, input logic [3:0] ty, input logic [31:0] a);
      if (pipe == 0) begin
         bus.p0_op_valid = v; bus.p0_op_type = ty; bus.p0_op_addr = a;
      end else begin
         bus.p1_op_valid = v; bus.p1_op_type = ty; bus.p1_op_addr = a;
      end
   endtask

   task automatic drive_we(input int pipe, input logic v, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [WAYS-1:0] w, input logic u);
      if (pipe == 0) begin
         bus.p0_we_valid = v; bus.p0_we_addr = a; bus.p0_we_data = d;
         bus.p0_we_strobe = s; bus.p0_we_sel = w; bus.p0_we_uncached = u;
      end else begin
         bus.p1_we_valid = v; bus.p1_we_addr = a; bus.p1_we_data = d;
         bus.p1_we_strobe = s; bus.p1_we_sel = w; bus.p1_we_uncached = u;
      end
   endtask

   task automatic clear_inputs();
      drive_op(0, 1'b0, 4'd0, 32'd0);
      drive_op(1, 1'b0, 4'd0, 32'd0);
      drive_we(0, 1'b0, 32'd0, 32'd0, 4'd0, '0, 1'b0);
      drive_we(1, 1'b0, 32'd0, 32'd0, 4'd0, '0, 1'b0);
      bus.dm_op_ready = 1'b0;
      bus.dm_we_ready = 1'b0;
   endtask

   function automatic logic [7:0] idx_of(input logic [31:0] a);
      return a[11:4];
   endfunction

   function automatic logic [31:0] rnd_addr();
      logic [31:0] a;
      a = $urandom & 32'hFFFF_F00F;
      a[11:4] = 8'($urandom_range(0, 3));
      return a;
   endfunction

   // ---------------- write-path vector table ----------------
   typedef struct {
      logic p0v; logic [31:0] p0d; logic [3:0] p0s; logic [WAYS-1:0] p0w; logic p0u;
      logic p1v; logic [31:0] p1d; logic [3:0] p1s; logic [WAYS-1:0] p1w; logic p1u;
      logic rdy;
      logic e_v; logic [31:0] e_d; logic [3:0] e_s; logic [WAYS-1:0] e_w; logic e_u;
      logic e_r0; logic e_r1;
   } vec_t;

   vec_t vecs[6];

   // ---------------- reference model state ----------------
   int          m_owner;   // -1 none, 0 pipe0, 1 pipe1
   int          m_prev;
   logic [3:0]  m_type;
   logic [31:0] m_addr;
   int          m_starve;
   logic        m_busy, m_hz0, m_hz1, m_s0, m_s1;
   logic        e_r0, e_r1, done0, done1;
   logic [31:0] e_data;
   logic [3:0]  e_strb;
   logic [WAYS-1:0] e_sel;
   logic        e_unc;

   initial begin
      vecs[0] = '{1'b0, 32'h0, 4'h0, 2'b00, 1'b0,  1'b0, 32'h0, 4'h0, 2'b00, 1'b0,  1'b1,
                  1'b0, 32'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{1'b1, 32'hA5A5_0001, 4'hF, 2'b01, 1'b0,  1'b0, 32'h0, 4'h0, 2'b00, 1'b0,  1'b1,
                  1'b1, 32'hA5A5_0001, 4'hF, 2'b01, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{1'b0, 32'h0, 4'h0, 2'b00, 1'b0,  1'b1, 32'h1234_5678, 4'h3, 2'b10, 1'b1,  1'b1,
                  1'b1, 32'h1234_5678, 4'h3, 2'b10, 1'b1, 1'b0, 1'b1};
      vecs[3] = '{1'b1, 32'hCAFE_0000, 4'hC, 2'b01, 1'b0,  1'b1, 32'hBEEF_0000, 4'h1, 2'b10, 1'b0,  1'b1,
                  1'b1, 32'hCAFE_0000, 4'hC, 2'b01, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{1'b1, 32'hCAFE_0000, 4'hC, 2'b01, 1'b0,  1'b1, 32'hBEEF_0000, 4'h1, 2'b10, 1'b0,  1'b0,
                  1'b1, 32'hCAFE_0000, 4'hC, 2'b01, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{1'b0, 32'h0, 4'h0, 2'b00, 1'b0,  1'b1, 32'h0000_00FF, 4'h1, 2'b10, 1'b0,  1'b0,
                  1'b1, 32'h0000_00FF, 4'h1, 2'b10, 1'b0, 1'b0, 1'b0};

      // ---------- reset: outputs held at zero ----------
      rst_n = 1'b0;
      clear_inputs();
      drive_we(0, 1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF, 2'b01, 1'b1);
      bus.dm_we_ready = 1'b1;
      bus.dm_op_ready = 1'b1;
      repeat (3) tick();
      sample();
      check("rst_dm_op_valid", bus.dm_op_valid, 1'b0);
      check("rst_dm_we_valid", bus.dm_we_valid, 1'b0);
      check("rst_dm_we_data", bus.dm_we_data, 32'd0);
      check("rst_p0_we_ready", bus.p0_we_ready, 1'b0);
      check("rst_p0_op_ready", bus.p0_op_ready, 1'b0);
      tick();
      rst_n = 1'b1;
      bus.dm_op_ready = 1'b0;
      sample();
      check("rel_dm_we_valid", bus.dm_we_valid, 1'b1);
      check("rel_dm_we_data", bus.dm_we_data, 32'hDEAD_BEEF);
      check("rel_dm_op_valid", bus.dm_op_valid, 1'b0);
      check("rel_starve", dbg_starve, 8'd0);
      tick();
      clear_inputs();
      tick();

      // ---------- write-path table (op FSM idle) ----------
      for (int i = 0; i < 6; i++) begin
         drive_we(0, vecs[i].p0v, 32'h100, vecs[i].p0d, vecs[i].p0s, vecs[i].p0w, vecs[i].p0u);
         drive_we(1, vecs[i].p1v, 32'h200, vecs[i].p1d, vecs[i].p1s, vecs[i].p1w, vecs[i].p1u);
         bus.dm_we_ready = vecs[i].rdy;
         sample();
         check($sformatf("vec%0d_valid", i), bus.dm_we_valid, vecs[i].e_v);
         check($sformatf("vec%0d_data", i), bus.dm_we_data, vecs[i].e_d);
         check($sformatf("vec%0d_strobe", i), bus.dm_we_strobe, vecs[i].e_s);
         check($sformatf("vec%0d_sel", i), bus.dm_we_sel, vecs[i].e_w);
         check($sformatf("vec%0d_unc", i), bus.dm_we_uncached, vecs[i].e_u);
         check($sformatf("vec%0d_r0", i), bus.p0_we_ready, vecs[i].e_r0);
         check($sformatf("vec%0d_r1", i), bus.p1_we_ready, vecs[i].e_r1);
         tick();
      end
      clear_inputs();
      tick();

      // ---------- single op: refill, completion at t=5 ----------
      drive_op(0, 1'b1, 4'b0001, 32'h1000_0040);
      for (int t = 0; t <= 6; t++) begin
         bus.dm_op_ready = (t == 5);
         if (t == 6) bus.p0_op_valid = 1'b0;
         sample();
         check($sformatf("op1_valid_t%0d", t), bus.dm_op_valid, (t >= 1 && t <= 5));
         check($sformatf("op1_p0_ready_t%0d", t), bus.p0_op_ready, (t == 5));
         if (t == 1) begin
            check("op1_addr", bus.dm_op_addr, 32'h1000_0040);
            check("op1_type", bus.dm_op_type, 4'b0001);
         end
         tick();
      end
      clear_inputs();

      // ---------- simultaneous p0/p1 ops ----------
      drive_op(0, 1'b1, 4'b0010, 32'h2000_0010);
      drive_op(1, 1'b1, 4'b0001, 32'h3000_0020);
      for (int t = 0; t <= 8; t++) begin
         bus.dm_op_ready = (t == 3 || t == 7);
         if (t == 4) bus.p0_op_valid = 1'b0;
         if (t == 8) bus.p1_op_valid = 1'b0;
         sample();
         check($sformatf("op2_valid_t%0d", t), bus.dm_op_valid, ((t >= 1 && t <= 3) || (t >= 5 && t <= 7)));
         check($sformatf("op2_p0_ready_t%0d", t), bus.p0_op_ready, (t == 3));
         check($sformatf("op2_p1_ready_t%0d", t), bus.p1_op_ready, (t == 7));
         if (t == 1) check("op2_first_addr", bus.dm_op_addr, 32'h2000_0010);
         if (t == 5) check("op2_second_addr", bus.dm_op_addr, 32'h3000_0020);
         tick();
      end
      clear_inputs();

      // ---------- starvation: p0 back-to-back, p1 waiting ----------
      for (int t = 0; t <= 6; t++) begin
         bus.dm_op_ready = (t == 1 || t == 3 || t == 5);
         if (t == 0) drive_op(0, 1'b1, 4'b0001, 32'h4000_0000);
         if (t == 2) drive_op(0, 1'b1, 4'b0001, 32'h4000_0100);
         if (t == 4) drive_op(0, 1'b1, 4'b0001, 32'h4000_0200);
         if (t == 6) drive_op(0, 1'b0, 4'b0000, 32'h0);
         if (t == 2) drive_op(1, 1'b1, 4'b0100, 32'h5000_0030);
         if (t == 6) drive_op(1, 1'b0, 4'b0000, 32'h0);
         sample();
         if (t == 2) check("starve_bubble", bus.dm_op_valid, 1'b0);
         if (t == 3) check("starve_p0_second", bus.dm_op_addr, 32'h4000_0100);
         if (t == 4) check("starve_at_limit", dbg_starve, 8'd2);
         if (t == 5) begin
            check("starve_p1_addr", bus.dm_op_addr, 32'h5000_0030);
            check("starve_cleared", dbg_starve, 8'd0);
            check("starve_p1_ready", bus.p1_op_ready, 1'b1);
            check("starve_p0_not_ready", bus.p0_op_ready, 1'b0);
         end
         if (t == 6) check("starve_idle", bus.dm_op_valid, 1'b0);
         tick();
      end
      clear_inputs();
      tick();

      // ---------- simultaneous writes, order via scoreboard ----------
      drive_we(0, 1'b1, 32'h300, 32'h1111_0000, 4'hF, 2'b01, 1'b0);
      drive_we(1, 1'b1, 32'h400, 32'h2222_0000, 4'h3, 2'b10, 1'b0);
      bus.dm_we_ready = 1'b1;
      exp_q.push_back(32'h1111_0000);
      exp_q.push_back(32'h2222_0000);
      for (int t = 0; t <= 1; t++) begin
         if (t == 1) bus.p0_we_valid = 1'b0;
         sample();
         check($sformatf("wr2_p0_ready_t%0d", t), bus.p0_we_ready, (t == 0));
         check($sformatf("wr2_p1_ready_t%0d", t), bus.p1_we_ready, (t == 1));
         if (bus.dm_we_valid && bus.dm_we_ready) begin
            if (exp_q.size() == 0) check("wr2_unexpected", bus.dm_we_data, 32'hFFFF_FFFF);
            else check($sformatf("wr2_data_t%0d", t), bus.dm_we_data, exp_q.pop_front());
         end
         tick();
      end
      check("wr2_queue_empty", exp_q.size(), 32'd0);
      clear_inputs();
      tick();

      // ---------- write hazard against in-flight GNT0 ----------
      bus.dm_we_ready = 1'b1;
      drive_op(0, 1'b1, 4'b0100, 32'h0000_0120);
      for (int t = 0; t <= 8; t++) begin
         bus.dm_op_ready = (t == 3 || t == 7);
         if (t == 1) drive_we(1, 1'b1, 32'h0000_8120, 32'h7777_0000, 4'hF, 2'b01, 1'b0);
         if (t == 4) drive_op(0, 1'b0, 4'b0000, 32'h0);
         if (t == 5) begin
            drive_we(1, 1'b0, 32'h0, 32'h0, 4'h0, 2'b00, 1'b0);
            drive_op(0, 1'b1, 4'b0100, 32'h0000_0120);
         end
         if (t == 6) drive_we(1, 1'b1, 32'h0000_0130, 32'h8888_0000, 4'h1, 2'b10, 1'b0);
         if (t == 7) drive_we(1, 1'b1, 32'h0000_0130, 32'h9999_0000, 4'h1, 2'b10, 1'b1);
         if (t == 8) clear_inputs();
         sample();
         if (t >= 1 && t <= 3) check($sformatf("hz_same_idx_t%0d", t), bus.p1_we_ready, 1'b0);
         if (t == 4) check("hz_released", bus.p1_we_ready, 1'b1);
         if (t == 6) begin
            check("hz_other_idx", bus.p1_we_ready, 1'b1);
            check("hz_other_data", bus.dm_we_data, 32'h8888_0000);
         end
         if (t == 7) begin
            check("hz_uncached", bus.p1_we_ready, 1'b0);
            check("hz_op_done", bus.p0_op_ready, 1'b1);
         end
         tick();
      end
      clear_inputs();
      tick();

      // ---------- reset in the middle of GNT1 ----------
      drive_op(1, 1'b1, 4'b0010, 32'h6000_0040);
      for (int t = 0; t <= 4; t++) begin
         if (t == 2) begin rst_n = 1'b0; bus.dm_op_ready = 1'b1; end
         if (t == 3) begin rst_n = 1'b1; bus.p1_op_valid = 1'b0; end
         if (t == 4) bus.dm_op_ready = 1'b0;
         sample();
         check($sformatf("rstg_valid_t%0d", t), bus.dm_op_valid, (t == 1));
         check($sformatf("rstg_p1_ready_t%0d", t), bus.p1_op_ready, 1'b0);
         if (t == 2) check("rstg_op_addr", bus.dm_op_addr, 32'd0);
         tick();
      end
      clear_inputs();
      tick();

      // ---------- randomized traffic vs reference model ----------
      m_owner = -1; m_type = 4'd0; m_addr = 32'd0; m_starve = 0;
      done0 = 1'b0; done1 = 1'b0;
      for (int c = 0; c < 600; c++) begin
         if (bus.p0_op_valid && !done0) begin
            if ($urandom_range(0, 15) == 0) bus.p0_op_valid = 1'b0;
         end else begin
            drive_op(0, ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)), rnd_addr());
         end
         if (bus.p1_op_valid && !done1) begin
            if ($urandom_range(0, 15) == 0) bus.p1_op_valid = 1'b0;
         end else begin
            drive_op(1, ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)), rnd_addr());
         end
         drive_we(0, !bus.p0_op_valid && ($urandom_range(0, 1) == 1), rnd_addr(), $urandom,
                  4'($urandom_range(0, 15)), WAYS'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
         drive_we(1, !bus.p1_op_valid && ($urandom_range(0, 1) == 1), rnd_addr(), $urandom,
                  4'($urandom_range(0, 15)), WAYS'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
         bus.dm_op_ready = ($urandom_range(0, 2) == 0);
         bus.dm_we_ready = ($urandom_range(0, 1) == 1);
         sample();

         // expected outputs from the current model state
         m_busy = (m_owner != -1);
         m_hz0  = m_busy && (bus.p0_we_uncached || idx_of(bus.p0_we_addr) == idx_of(m_addr));
         m_hz1  = m_busy && (bus.p1_we_uncached || idx_of(bus.p1_we_addr) == idx_of(m_addr));
         m_s0   = bus.p0_we_valid && !m_hz0;
         m_s1   = bus.p1_we_valid && !bus.p0_we_valid && !m_hz1;
         e_data = m_s0 ? bus.p0_we_data : (m_s1 ? bus.p1_we_data : 32'd0);
         e_strb = m_s0 ? bus.p0_we_strobe : (m_s1 ? bus.p1_we_strobe : 4'd0);
         e_sel  = m_s0 ? bus.p0_we_sel : (m_s1 ? bus.p1_we_sel : '0);
         e_unc  = m_s0 ? bus.p0_we_uncached : (m_s1 ? bus.p1_we_uncached : 1'b0);
         e_r0   = (m_owner == 0) && bus.dm_op_ready && bus.p0_op_valid;
         e_r1   = (m_owner == 1) && bus.dm_op_ready && bus.p1_op_valid;

         check("rnd_dm_op_valid", bus.dm_op_valid, m_busy);
         check("rnd_dm_op_addr", bus.dm_op_addr, m_busy ? m_addr : 32'd0);
         check("rnd_dm_op_type", bus.dm_op_type, m_busy ? m_type : 4'd0);
         check("rnd_p0_op_ready", bus.p0_op_ready, e_r0);
         check("rnd_p1_op_ready", bus.p1_op_ready, e_r1);
         check("rnd_starve", dbg_starve, m_starve);
         check("rnd_dm_we_valid", bus.dm_we_valid, m_s0 || m_s1);
         check("rnd_dm_we_data", bus.dm_we_data, e_data);
         check("rnd_dm_we_strobe", bus.dm_we_strobe, e_strb);
         check("rnd_dm_we_sel", bus.dm_we_sel, e_sel);
         check("rnd_dm_we_unc", bus.dm_we_uncached, e_unc);
         check("rnd_p0_we_ready", bus.p0_we_ready, m_s0 && bus.dm_we_ready);
         check("rnd_p1_we_ready", bus.p1_we_ready, m_s1 && bus.dm_we_ready);
         done0 = e_r0;
         done1 = e_r1;

         // advance the model by one clock
         m_prev = m_owner;
         if (m_owner != -1) begin
            if (bus.dm_op_ready) m_owner = -1;
         end else if (m_starve == LIMIT && bus.p1_op_valid) begin
            m_owner = 1; m_type = bus.p1_op_type; m_addr = bus.p1_op_addr;
         end else if (bus.p0_op_valid) begin
            m_owner = 0; m_type = bus.p0_op_type; m_addr = bus.p0_op_addr;
         end else if (bus.p1_op_valid) begin
            m_owner = 1; m_type = bus.p1_op_type; m_addr = bus.p1_op_addr;
         end
         if (!bus.p1_op_valid || (m_prev == -1 && m_owner == 1)) m_starve = 0;
         else if (m_prev != 1 && m_starve < LIMIT) m_starve = m_starve + 1;
         tick();
      end

      // ---------- final report ----------
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
